mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the single-issue core: drives the program counter, instruction register, register-file write port and data-memory strobes through FETCH/DECODE/EXEC/MEM/WB so that `pc_reg`, `ID`, `RegFile` and the ALU share one datapath across several cycles per instruction. It replaces the fixed tie-offs of the bring-up frame (constant `jump`, zero write data) with real per-instruction control. It also provides a retired-instruction counter and a sticky fault for illegal instructions or memory stalls.

---
 rtl/mc_ctrl.sv | 130 +++++++++++++
 tb/tb_mc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller: steps one instruction through FETCH/DECODE/EXEC/MEM/WB,
// counts retired instructions and traps illegal instructions or memory timeouts in FAULT.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch,
    input  logic             jump,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             regwrite,
    input  logic             illegal,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             br_taken_q;
    logic             commit;
    logic             stalled;

    assign tmo_hit = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
    assign stalled = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM) && !dmem_ready);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (illegal || (memread && memwrite)) state_d = S_FAULT;
                else                                   state_d = S_EXEC;
            end
            S_EXEC: begin
                if (memread || memwrite) state_d = S_MEM;
                else if (regwrite)       state_d = S_WB;
                else                     commit  = 1'b1;
            end
            S_MEM: begin
                dmem_re = memread;
                dmem_we = memwrite;
                if (dmem_ready) begin
                    if (memread && regwrite) state_d = S_WB;
                    else                     commit  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                commit = 1'b1;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
        if (commit) begin
            pc_we   = 1'b1;
            // A commit in EXEC sees the live compare; later commits use the copy taken at EXEC.
            pc_sel  = jump | (branch & ((state_q == S_EXEC) ? br_taken : br_taken_q));
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            retired    <= '0;
            tmo_cnt    <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (commit) retired <= retired + CNT_W'(1);
            if (state_q == S_EXEC) br_taken_q <= br_taken;
            if (state_d != state_q) tmo_cnt <= '0;
            else if (stalled)       tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign state = state_q;
    assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and randomized instructions checked against an expected
// per-cycle trace built from the instruction's class and the memory wait counts.
module tb_mc_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_we;
        logic       dmem_re;
        logic       dmem_we;
        logic       rf_we;
        logic       pc_we;
        logic       fault;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          imem_ready, dmem_ready;
    logic          branch = 1'b0, jump = 1'b0, memread = 1'b0, memwrite = 1'b0;
    logic          regwrite = 1'b0, illegal = 1'b0, br_taken = 1'b0;
    logic          imem_req, ir_we, pc_we, pc_sel, dmem_re, dmem_we, rf_we, fault;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    int            vectors = 0;
    int            miscompares = 0;
    int            imem_wait = 0, dmem_wait = 0;
    int            icnt = 0, dcnt = 0;
    logic [CW-1:0] exp_ret = '0;

    mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .branch(branch), .jump(jump), .memread(memread), .memwrite(memwrite),
        .regwrite(regwrite), .illegal(illegal), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we),
        .state(state), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    // Memory responders: ready after a programmed number of wait cycles per request.
    assign imem_ready = imem_req && (icnt >= imem_wait);
    assign dmem_ready = (dmem_re || dmem_we) && (dcnt >= dmem_wait);
    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= ((dmem_re || dmem_we) && !dmem_ready) ? dcnt + 1 : 0;
    end

    wire [9:0] obs = {state, imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, fault};

    function automatic exp_t mk(input int st, input logic ireq, irwe, dre, dwe, rfwe, pcwe, flt);
        mk = {3'(st), ireq, irwe, dre, dwe, rfwe, pcwe, flt};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step_check(input string tag, input exp_t e);
        @(negedge clk);
        #1;
        check(tag, 32'(obs), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_ret = '0;
        check("rst_obs", 32'(obs), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        {branch, jump, memread, memwrite, regwrite, illegal, br_taken} = '0;
        run = 1'b0;
        imem_wait = 0;
        dmem_wait = 0;
        reset = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Called at the first FETCH cycle; returns at the first cycle after the commit.
    task automatic run_instr(input logic br, jp, mr, mw, rw, bt, input int fw, dw, input logic run_next);
        exp_t q[$];
        logic mem, wb, psel;
        branch = br; jump = jp; memread = mr; memwrite = mw; regwrite = rw;
        illegal = 1'b0; br_taken = bt;
        imem_wait = fw; dmem_wait = dw;
        mem  = mr | mw;
        wb   = mem ? (mr & rw) : rw;
        psel = jp | (br & bt);
        for (int i = 0; i <= fw; i++) q.push_back(mk(1, 1, i == fw, 0, 0, 0, 0, 0));
        q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(3, 0, 0, 0, 0, 0, !mem && !rw, 0));
        if (mem)
            for (int i = 0; i <= dw; i++) q.push_back(mk(4, 0, 0, mr, mw, 0, (i == dw) && !wb, 0));
        if (wb) q.push_back(mk(5, 0, 0, 0, 0, 1, 1, 0));
        #1;
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                // The compare result is only valid in EXEC; scramble it afterwards.
                if (q[k-1].st == 3'd3) br_taken = 1'($urandom_range(0, 1));
                #1;
            end
            if (q[k].st == 3'd3) run = run_next;
            check("cycle", 32'(obs), 32'(q[k]));
            if (q[k].pc_we) check("pc_sel", 32'(pc_sel), 32'(psel));
        end
        exp_ret = exp_ret + CW'(1);
        @(negedge clk);
        #1;
        check("retired", 32'(retired), 32'(exp_ret));
        check("after_commit", 32'(state), run_next ? 32'd1 : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] kind;
        #2;
        check("rst_obs", 32'(obs), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step_check("idle_hold", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step_check("idle_hold", mk(0, 0, 0, 0, 0, 0, 0, 0));
        start_run();

        run_instr(0, 0, 0, 0, 1, 0, 0, 0, 1);   // ALU op with write-back
        run_instr(0, 0, 1, 0, 1, 0, 0, 3, 1);   // load, three data wait cycles
        run_instr(1, 0, 0, 0, 0, 1, 0, 0, 1);   // branch taken
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 1);   // branch not taken
        run_instr(0, 1, 0, 1, 0, 0, 1, 2, 1);   // store with jump, commit in MEM
        run_instr(1, 0, 1, 0, 1, 1, 2, 1, 1);   // load with taken branch, commit in WB

        for (int i = 0; i < 40; i++) begin
            kind = 2'($urandom_range(0, 2));
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      kind == 2'd1, kind == 2'd2, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                      i != 39);
        end
        step_check("idle_park", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Fetch ready on the 15th cycle, then a fetch that never completes.
        start_run();
        run_instr(0, 0, 0, 0, 1, 0, 14, 0, 1);
        imem_wait = 1000;
        #1;
        check("fetch_wait", 32'(state), 32'd1);
        for (int k = 1; k < 15; k++) step_check("fetch_wait", mk(1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) step_check("fetch_tmo", mk(7, 0, 0, 0, 0, 0, 0, 1));
        do_reset();

        // Data ready on the 15th cycle, then a load that never completes.
        start_run();
        run_instr(0, 0, 1, 0, 1, 0, 0, 14, 1);
        memread = 1'b1; regwrite = 1'b1; dmem_wait = 1000;
        #1;
        check("mem_tmo_f", 32'(obs), 32'(mk(1, 1, 1, 0, 0, 0, 0, 0)));
        step_check("mem_tmo_d", mk(2, 0, 0, 0, 0, 0, 0, 0));
        step_check("mem_tmo_e", mk(3, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 15; k++) step_check("mem_wait", mk(4, 0, 0, 1, 0, 0, 0, 0));
        step_check("mem_tmo", mk(7, 0, 0, 0, 0, 0, 0, 1));
        do_reset();

        // Illegal instruction, then both memory controls at once.
        start_run();
        illegal = 1'b1;
        #1;
        check("ill_f", 32'(obs), 32'(mk(1, 1, 1, 0, 0, 0, 0, 0)));
        step_check("ill_d", mk(2, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) step_check("ill_fault", mk(7, 0, 0, 0, 0, 0, 0, 1));
        do_reset();
        start_run();
        memread = 1'b1; memwrite = 1'b1;
        #1;
        check("rw_f", 32'(obs), 32'(mk(1, 1, 1, 0, 0, 0, 0, 0)));
        step_check("rw_d", mk(2, 0, 0, 0, 0, 0, 0, 0));
        step_check("rw_fault", mk(7, 0, 0, 0, 0, 0, 0, 1));
        do_reset();

        // Asynchronous reset in the middle of a stalled store.
        start_run();
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, 1);
        memwrite = 1'b1; regwrite = 1'b0; dmem_wait = 10;
        #1;
        check("st_f", 32'(obs), 32'(mk(1, 1, 1, 0, 0, 0, 0, 0)));
        step_check("st_d", mk(2, 0, 0, 0, 0, 0, 0, 0));
        step_check("st_e", mk(3, 0, 0, 0, 0, 0, 0, 0));
        step_check("st_mem", mk(4, 0, 0, 0, 1, 0, 0, 0));
        check("st_retired", 32'(retired), 32'(exp_ret));
        #1;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
